// File: rtl/serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each held for CLKS_PER_BIT clocks. TXD is driven straight from a flop.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              VALID,
    output logic              READY,
    output logic              TXD,
    output logic              BUSY
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state, state_nxt;
    logic              txd_q, txd_nxt;
    logic [CW-1:0]     cyc_cnt, cyc_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              bit_done;

    assign bit_done = (cyc_cnt == CYC_LAST);

    // NOTE: every registered signal gets a default first, so no path through this block
    // leaves a variable unassigned and no latch can be inferred.
    always_comb begin
        state_nxt = state;
        txd_nxt   = txd_q;
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        unique case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                // READY is implied by being in IDLE, so VALID alone marks the accept edge.
                if (VALID) begin
                    shift_nxt = DIN;
                    txd_nxt   = 1'b0;
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cyc_nxt   = '0;
                    txd_nxt   = shift[0];
                    state_nxt = DATA;
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cyc_nxt   = '0;
                    shift_nxt = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        txd_nxt   = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                        txd_nxt = shift_nxt[0];
                    end
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    cyc_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            txd_q   <= 1'b1;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            txd_q   <= txd_nxt;
            cyc_cnt <= cyc_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
        end
    end

    assign READY = (state == IDLE);
    assign BUSY  = (state != IDLE);
    assign TXD   = txd_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one instance at 4 clocks/bit, one at 1 clock/bit, each compared
// cycle by cycle against a frame model computed from bit position arithmetic.
module tb_serial_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din_a = '0;
    logic [DW-1:0] din_b = '0;
    logic          valid_a = 1'b0;
    logic          valid_b = 1'b0;
    logic          ready_a, txd_a, busy_a;
    logic          ready_b, txd_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .CLK(clk), .RST(rst), .DIN(din_a), .VALID(valid_a),
        .READY(ready_a), .TXD(txd_a), .BUSY(busy_a)
    );

    serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut_fast (
        .CLK(clk), .RST(rst), .DIN(din_b), .VALID(valid_b),
        .READY(ready_b), .TXD(txd_b), .BUSY(busy_b)
    );

    // Line level idx cycles after the first low cycle of a frame carrying w.
    function automatic logic model_bit(input logic [DW-1:0] w, input int idx, input int cpb);
        int pos;
        pos = idx / cpb;
        if (pos == 0) return 1'b0;
        if (pos <= DW) return w[pos-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents w for one accept edge, then records how the line and BUSY behave for a full frame.
    task automatic send_and_capture(input bit fast, input logic [DW-1:0] w, input bit scramble,
                                    output int errs, output int first_bad, output int busy_cycles);
        int cpb;
        int len;
        logic t;
        logic b;
        cpb = fast ? 1 : CPB;
        len = (DW + 2) * cpb;
        if (fast) begin din_b = w; valid_b = 1'b1; end
        else      begin din_a = w; valid_a = 1'b1; end
        tick();
        valid_a = 1'b0;
        valid_b = 1'b0;
        errs = 0;
        first_bad = -1;
        busy_cycles = 0;
        for (int i = 0; i < len; i++) begin
            t = fast ? txd_b : txd_a;
            b = fast ? busy_b : busy_a;
            if (t !== model_bit(w, i, cpb)) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
            if (b === 1'b1) busy_cycles++;
            if (scramble) begin
                if (fast) din_b = DW'($urandom);
                else      din_a = DW'($urandom);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({ready_a, busy_a, txd_a} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/busy/txd=%b required 101", {ready_a, busy_a, txd_a});
        end
        n_tests++;
        if ({ready_b, busy_b, txd_b} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_outputs_fast: ready/busy/txd=%b required 101", {ready_b, busy_b, txd_b});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int errs, first_bad, busy_cycles;
        din_a = 8'hA5;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        n_tests++;
        if (ready_a !== 1'b0 || txd_a !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_latency: ready=%b txd=%b required ready=0 txd=0", ready_a, txd_a);
        end
        errs = 0; first_bad = -1; busy_cycles = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (txd_a !== model_bit(8'hA5, i, CPB)) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
            if (busy_a === 1'b1) busy_cycles++;
            tick();
        end
        n_tests++;
        if (errs != 0 || busy_cycles != FRAME) begin
            n_fail++;
            $display("FAIL frame_a5: %0d bad cycles (first %0d), busy %0d cycles; required 0 bad, busy %0d",
                     errs, first_bad, busy_cycles, FRAME);
        end
        n_tests++;
        if (ready_a !== 1'b1 || txd_a !== 1'b1) begin
            n_fail++;
            $display("FAIL after_frame_a5: ready=%b txd=%b required 1/1", ready_a, txd_a);
        end
    endtask

    task automatic test_back_to_back();
        int errs, second_fall;
        logic exp, ready_gap;
        din_a = 8'h00;
        valid_a = 1'b1;
        tick();
        din_a = 8'hFF;
        errs = 0;
        second_fall = -1;
        ready_gap = 1'b0;
        for (int i = 0; i <= 2 * FRAME; i++) begin
            if (i < FRAME)       exp = model_bit(8'h00, i, CPB);
            else if (i == FRAME) exp = 1'b1;
            else                 exp = model_bit(8'hFF, i - FRAME - 1, CPB);
            if (txd_a !== exp) errs++;
            if (i == FRAME) ready_gap = ready_a;
            if (i > FRAME && txd_a === 1'b0 && second_fall < 0) second_fall = i;
            if (i == FRAME + 1) valid_a = 1'b0;
            tick();
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL back_to_back_line: %0d bad cycles required 0", errs);
        end
        n_tests++;
        if (ready_gap !== 1'b1 || second_fall != FRAME + 1) begin
            n_fail++;
            $display("FAIL back_to_back_period: gap ready=%b period=%0d required ready=1 period=%0d",
                     ready_gap, second_fall, FRAME + 1);
        end
    endtask

    task automatic test_ignore_busy();
        logic [DW-1:0] w;
        int errs, extra_bad;
        w = DW'($urandom);
        din_a = w;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        errs = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (txd_a !== model_bit(w, i, CPB)) errs++;
            if (i == 10) begin din_a = 8'h3C; valid_a = 1'b1; end
            if (i == FRAME - 3) valid_a = 1'b0;
            tick();
        end
        extra_bad = 0;
        for (int i = 0; i < 2 * CPB; i++) begin
            if (txd_a !== 1'b1 || ready_a !== 1'b1) extra_bad++;
            tick();
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL ignore_busy_frame: word %h, %0d bad cycles required 0", w, errs);
        end
        n_tests++;
        if (extra_bad != 0) begin
            n_fail++;
            $display("FAIL ignore_busy_idle: %0d non-idle cycles after frame required 0", extra_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int errs, first_bad, busy_cycles, idle_bad;
        din_a = 8'h5A;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        errs = 0;
        // Cycle 17 falls inside data bit 3 (bits occupy 4 cycles each after the start bit).
        for (int i = 0; i <= 17; i++) begin
            if (txd_a !== model_bit(8'h5A, i, CPB)) errs++;
            if (i < 17) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (errs != 0 || {ready_a, busy_a, txd_a} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_mid_frame: prefix bad=%0d ready/busy/txd=%b required 0 and 101",
                     errs, {ready_a, busy_a, txd_a});
        end
        idle_bad = 0;
        for (int i = 0; i < 2 * CPB; i++) begin
            if (txd_a !== 1'b1 || ready_a !== 1'b1) idle_bad++;
            tick();
        end
        n_tests++;
        if (idle_bad != 0) begin
            n_fail++;
            $display("FAIL reset_no_residue: %0d non-idle cycles required 0", idle_bad);
        end
        rst = 1'b1;
        din_a = 8'h00;
        valid_a = 1'b1;
        tick();
        rst = 1'b0;
        valid_a = 1'b0;
        tick();
        n_tests++;
        if (ready_a !== 1'b1 || txd_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_beats_valid: ready=%b txd=%b required 1/1", ready_a, txd_a);
        end
        send_and_capture(1'b0, 8'h81, 1'b0, errs, first_bad, busy_cycles);
        n_tests++;
        if (errs != 0 || busy_cycles != FRAME) begin
            n_fail++;
            $display("FAIL frame_after_reset_81: bad=%0d (first %0d) busy=%0d required 0 and %0d",
                     errs, first_bad, busy_cycles, FRAME);
        end
    endtask

    task automatic test_one_clk_per_bit();
        int errs, first_bad, busy_cycles;
        send_and_capture(1'b1, 8'hC3, 1'b0, errs, first_bad, busy_cycles);
        n_tests++;
        if (errs != 0 || busy_cycles != DW + 2) begin
            n_fail++;
            $display("FAIL fast_frame_c3: bad=%0d (first %0d) busy=%0d required 0 and %0d",
                     errs, first_bad, busy_cycles, DW + 2);
        end
        n_tests++;
        if (ready_b !== 1'b1 || txd_b !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_after_frame: ready=%b txd=%b required 1/1", ready_b, txd_b);
        end
    endtask

    task automatic test_din_scramble();
        int errs, first_bad, busy_cycles;
        send_and_capture(1'b0, 8'h96, 1'b1, errs, first_bad, busy_cycles);
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL din_scramble_96: bad=%0d (first %0d) required 0", errs, first_bad);
        end
    endtask

    task automatic test_random_frames();
        int errs, first_bad, busy_cycles, gap, len;
        logic [DW-1:0] w;
        bit fast;
        for (int k = 0; k < 16; k++) begin
            w = DW'($urandom);
            fast = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            len = fast ? (DW + 2) : FRAME;
            send_and_capture(fast, w, 1'b1, errs, first_bad, busy_cycles);
            n_tests++;
            if (errs != 0 || busy_cycles != len) begin
                n_fail++;
                $display("FAIL random_frame_%0d: word %h fast=%0d bad=%0d (first %0d) busy=%0d required 0 and %0d",
                         k, w, fast, errs, first_bad, busy_cycles, len);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_one_clk_per_bit();
        test_din_scramble();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
